instr_fetch_decode: RTL

//  Fetch/decode stage of the 16-bit non-pipelined core: owns the PC and instruction register (IR).

---
 rtl/core16_pkg.sv | 52 +++++
 rtl/pc_reg.sv | 34 +++
 rtl/signextender.sv | 25 ++
 rtl/instr_fetch_decode.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/core16_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : core16_pkg
//  Description : Shared definitions for the 16-bit non-pipelined core:
//                opcode map, instruction field positions and the
//                fetch/decode state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package core16_pkg;

  // Opcode map. HALT_OP stops the fetch stage.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] HALT_OP = 4'hF;

  // Instruction field bit positions.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Fetch/decode sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALT   = 2'd3
  } fd_state_t;

  // True when the opcode is the configured halt opcode.
  function automatic logic is_halt(input logic [3:0] op, input logic [3:0] halt_op);
    return (op == halt_op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : Program counter with synchronous reset, branch load and
//                wrapping increment. Load takes priority over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // PC update: reset, branch redirect, or increment (natural wrap at top).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/signextender.sv
`default_nettype none
// ============================================================================
//  Module      : signextender
//  Description : Registered 8-to-16 bit sign extender fed by the decode
//                stage immediate; output is valid one clock after input.
//  Revision    : 1.0  initial release
// ============================================================================
module signextender (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_8b,
  output logic [15:0] out_16b
);

  // Replicate the immediate sign bit into the upper byte every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_16b <= '0;
    end else begin
      out_16b <= {{8{in_8b[7]}}, in_8b};
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_decode
//  Description : Fetch/decode stage of the 16-bit non-pipelined core. Owns
//                the PC and IR, fetches one word at a time, exposes the
//                decoded fields and holds them until execute accepts.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_decode
  import core16_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = core16_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dec_valid,
  input  logic              exec_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  // The IR resets to zero, so opcode 0 must never mean halt, and the field
  // map assumes a 16-bit instruction word.
  generate
    if (HALT_OP == 4'h0) begin : g_halt_op_check
      $error("instr_fetch_decode: HALT_OP must not be 0 (IR reset value decodes as opcode 0)");
    end
    if (DATA_W != 16) begin : g_data_w_check
      $error("instr_fetch_decode: field layout requires DATA_W == 16");
    end
  endgenerate

  fd_state_t         r_state;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_pc_out;
  logic              r_imem_req;
  logic              r_dec_valid;
  logic              r_halted;

  logic [ADDR_W-1:0] w_pc;
  logic              w_fetch_done;
  logic              w_handshake;
  logic              w_pc_inc;
  logic              w_pc_load;

  // A fetch completes only while a request is actually outstanding; acks
  // seen with imem_req low (e.g. late acks after reset) are ignored.
  assign w_fetch_done = (r_state == ST_FETCH) && r_imem_req && imem_ack;
  assign w_handshake  = (r_state == ST_ISSUE) && r_dec_valid && exec_ready;
  assign w_pc_inc     = w_fetch_done;
  assign w_pc_load    = w_handshake && branch_taken;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .inc        (w_pc_inc),
    .load       (w_pc_load),
    .load_value (branch_target),
    .pc         (w_pc)
  );

  // Sequencer: FETCH raises the request, latches IR on ack, SETTLE gives the
  // downstream sign extender a cycle, ISSUE holds until execute accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_ir        <= '0;
      r_pc_out    <= '0;
      r_imem_req  <= 1'b0;
      r_dec_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_pc_out   <= w_pc;
            r_imem_req <= 1'b0;
            r_state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (is_halt(opcode, HALT_OP)) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_dec_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_ready) begin
            r_dec_valid <= 1'b0;
            r_state     <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_halted    <= 1'b1;
          r_imem_req  <= 1'b0;
          r_dec_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // Fields are plain slices of IR, so they only move when IR is loaded.
  assign opcode    = r_ir[OP_MSB:OP_LSB];
  assign rd        = r_ir[RD_MSB:RD_LSB];
  assign rs        = r_ir[RS_MSB:RS_LSB];
  assign rt        = r_ir[RT_MSB:RT_LSB];
  assign imm8      = r_ir[IMM_MSB:IMM_LSB];

  assign imem_req  = r_imem_req;
  assign imem_addr = w_pc;
  assign dec_valid = r_dec_valid;
  assign pc_out    = r_pc_out;
  assign halted    = r_halted;

endmodule
`default_nettype wire
